// File: rtl/ov5640_cfg_pkg.sv
// rtl/ov5640_cfg_pkg.sv - shared types and constants for the OV5640 register sequencer
package ov5640_cfg_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_SRST_WAIT,
    ST_DONE,
    ST_FAIL
  } cfg_state_e;

  localparam int EW_DEV_LSB = 24;
  localparam int EW_REG_LSB = 8;
  localparam int EW_DAT_LSB = 0;

  localparam logic [7:0]  DEV_ADDR_WR = 8'h78;
  localparam logic [15:0] SRST_REG    = 16'h3008;
  localparam logic [7:0]  SRST_VAL    = 8'h82;

  localparam int DLY_W = 20;

  function automatic logic [31:0] pack_ewdata(input logic [7:0] dev, input logic [23:0] entry);
    pack_ewdata = '0;
    pack_ewdata[EW_DEV_LSB +: 8]  = dev;
    pack_ewdata[EW_REG_LSB +: 16] = entry[23:8];
    pack_ewdata[EW_DAT_LSB +: 8]  = entry[7:0];
  endfunction

endpackage

// File: rtl/ov5640_cfg_rom.sv
// rtl/ov5640_cfg_rom.sv - combinational {reg_addr, reg_data} table for the OV5640 bring-up
module ov5640_cfg_rom
  import ov5640_cfg_pkg::*;
#(
  parameter int REG_NUM = 252
) (
  input  logic [7:0]  idx_i,
  output logic [23:0] entry_o
);

  always_comb begin
    entry_o = 24'h000000;
    if ({24'd0, idx_i} < 32'(REG_NUM)) begin
      case (idx_i)
        8'd0:    entry_o = {SRST_REG, SRST_VAL};
        8'd1:    entry_o = {16'h3008, 8'h42};
        8'd2:    entry_o = {16'h3103, 8'h03};
        8'd3:    entry_o = {16'h3017, 8'hff};
        8'd4:    entry_o = {16'h3018, 8'hff};
        8'd5:    entry_o = {16'h3034, 8'h1a};
        8'd6:    entry_o = {16'h3037, 8'h13};
        8'd7:    entry_o = {16'h3108, 8'h01};
        8'd8:    entry_o = {16'h3630, 8'h36};
        8'd9:    entry_o = {16'h3631, 8'h0e};
        8'd10:   entry_o = {16'h3632, 8'he2};
        8'd11:   entry_o = {16'h3633, 8'h12};
        8'd12:   entry_o = {16'h3621, 8'he0};
        8'd13:   entry_o = {16'h3704, 8'ha0};
        8'd14:   entry_o = {16'h3703, 8'h5a};
        8'd15:   entry_o = {16'h3715, 8'h78};
        default: entry_o = 24'h000000;
      endcase
    end
  end

endmodule

// File: rtl/ov5640_cfg_seq.sv
// rtl/ov5640_cfg_seq.sv - power-up delay, soft reset and table replay over SCCB with NACK retry
module ov5640_cfg_seq
  import ov5640_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR  = DEV_ADDR_WR,
  parameter int         REG_NUM   = 252,
  parameter int         PWR_DLY   = 1_000_000,
  parameter int         SRST_DLY  = 250_000,
  parameter int         MAX_RETRY = 3
) (
  input  logic        clk_sys50m,
  input  logic        rst,
  input  logic        iic_done,
  input  logic        iic_ack_err,
  output logic        estart,
  output logic [31:0] ewdata,
  output logic [7:0]  cfg_idx,
  output logic        cfg_done,
  output logic        cfg_fail
);

  localparam logic [DLY_W-1:0] PWR_LAST  = DLY_W'(PWR_DLY - 1);
  localparam logic [DLY_W-1:0] SRST_LAST = DLY_W'(SRST_DLY - 1);
  localparam logic [7:0]       IDX_LAST  = 8'(REG_NUM - 1);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);

  cfg_state_e       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       idx_q, idx_d;
  logic             estart_q, done_q, fail_q;
  logic [31:0]      ewdata_q;
  logic [23:0]      rom_entry;

  // The ROM is addressed with the next index so ewdata lands together with estart.
  ov5640_cfg_rom #(.REG_NUM(REG_NUM)) u_rom (
    .idx_i   (idx_d),
    .entry_o (rom_entry)
  );

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    case (state_q)
      ST_PWR_WAIT: begin
        if (dly_q == PWR_LAST) begin
          state_d = ST_ISSUE;
          idx_d   = 8'd0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      ST_ISSUE: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (iic_done) begin
          if (iic_ack_err) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + 8'd1;
              state_d = ST_ISSUE;
            end
          end else begin
            retry_d = 8'd0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end else if (idx_q == 8'd0) begin
              state_d = ST_SRST_WAIT;
              dly_d   = '0;
            end else begin
              idx_d   = idx_q + 8'd1;
              state_d = ST_ISSUE;
            end
          end
        end
      end
      ST_SRST_WAIT: begin
        if (dly_q == SRST_LAST) begin
          state_d = ST_ISSUE;
          idx_d   = 8'd1;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_sys50m) begin
    if (rst) begin
      state_q  <= ST_PWR_WAIT;
      dly_q    <= '0;
      retry_q  <= 8'd0;
      idx_q    <= 8'd0;
      estart_q <= 1'b0;
      ewdata_q <= 32'd0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      retry_q  <= retry_d;
      idx_q    <= idx_d;
      estart_q <= (state_d == ST_ISSUE);
      if (state_d == ST_ISSUE) begin
        ewdata_q <= pack_ewdata(DEV_ADDR, rom_entry);
      end
      done_q   <= (state_d == ST_DONE);
      fail_q   <= (state_d == ST_FAIL);
    end
  end

  assign estart   = estart_q;
  assign ewdata   = ewdata_q;
  assign cfg_idx  = idx_q;
  assign cfg_done = done_q;
  assign cfg_fail = fail_q;

endmodule

// File: doc/ov5640_cfg_seq.md
OV5640_CFG_SEQ -- requirements
Module: ov5640_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'h78: SCCB write device address placed in ewdata[31:24].
REQ-002 Parameter REG_NUM, default 252: number of table entries; 1..256.
REQ-003 Parameter PWR_DLY, default 1_000_000: clk_sys50m cycles waited after reset before the first write (20 ms).
REQ-004 Parameter SRST_DLY, default 250_000: cycles waited after entry 0 (soft reset 0x3008=0x82) completes (5 ms).
REQ-005 Parameter MAX_RETRY, default 3: re-issues allowed per entry after an ACK error.
REQ-006 clk_sys50m  in  1  system clock; the block has one clock, and reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 iic_done  in  1  one-cycle pulse from the SCCB controller when a transfer ends.
REQ-009 iic_ack_err  in  1  NACK flag; valid only while iic_done=1.
REQ-010 estart  out  1  one-cycle write request to the SCCB controller.
REQ-011 ewdata  out  32  {DEV_ADDR, reg_addr[15:0], reg_data[7:0]}.
REQ-012 cfg_idx  out  8  index of the entry currently being written.
REQ-013 cfg_done  out  1  level; all entries written successfully.
REQ-014 cfg_fail  out  1  level; retries exhausted on some entry.

Function
REQ-015 FSM states: PWR_WAIT, ISSUE, WAIT_ACK, SRST_WAIT, DONE, FAIL.
REQ-016 PWR_WAIT: a 20-bit counter counts to PWR_DLY-1, then the FSM moves to ISSUE with cfg_idx=0.
REQ-017 ISSUE: estart=1 for exactly one cycle and ewdata is loaded from the table at cfg_idx in the same cycle; next state is WAIT_ACK.
REQ-018 ewdata holds its value from the estart cycle until the iic_done cycle inclusive; it is never changed in WAIT_ACK.
REQ-019 WAIT_ACK ignores estart generation and waits indefinitely for iic_done; there is no timeout.
REQ-020 iic_done=1 with iic_ack_err=1 and retry count < MAX_RETRY: increment the retry count and return to ISSUE with the same cfg_idx.
REQ-021 iic_done=1 with iic_ack_err=1 and retry count = MAX_RETRY: go to FAIL.
REQ-022 iic_done=1 with iic_ack_err=0 and cfg_idx=0: clear the retry count and go to SRST_WAIT.
REQ-023 iic_done=1 with iic_ack_err=0 and cfg_idx=REG_NUM-1: go to DONE.
REQ-024 Any other success: clear the retry count, increment cfg_idx and go to ISSUE.
REQ-025 SRST_WAIT counts SRST_DLY cycles, then sets cfg_idx=1 and goes to ISSUE.
REQ-026 With REG_NUM=1, success on entry 0 goes to DONE; DONE takes precedence over SRST_WAIT.
REQ-027 DONE and FAIL are terminal until rst; cfg_done=1 only in DONE and cfg_fail=1 only in FAIL.
REQ-028 iic_done outside WAIT_ACK is ignored.
REQ-029 Minimum spacing between consecutive estart pulses is 2 cycles: ISSUE, then at least one WAIT_ACK cycle.
REQ-030 cfg_idx never exceeds REG_NUM-1; there is no wrap-around.

Reset
REQ-031 On rst=1 at a clock edge: state=PWR_WAIT, delay counter=0, retry=0, cfg_idx=0, estart=0, ewdata=0, cfg_done=0, cfg_fail=0.
REQ-032 rst asserted mid-transfer aborts the sequence; after release the full power-up delay and table replay restart from entry 0.
REQ-033 The block does not reset or hold off the SCCB controller; that controller shares rst.

Structure
REQ-034 Package ov5640_cfg_pkg holds the state encoding, the ewdata field offsets, and the constants DEV_ADDR_WR=8'h78 and SRST_REG=16'h3008.
REQ-035 Sub-module ov5640_cfg_rom is a combinational lookup: 8-bit index in, 24-bit {reg_addr, reg_data} out.
REQ-036 ov5640_cfg_rom entry 0 is fixed as {16'h3008, 8'h82}; out-of-range indices return {16'h0000, 8'h00}.
REQ-037 The delay counter is shared by PWR_WAIT and SRST_WAIT; it is 20 bits wide and cleared on each state entry.

Verification
REQ-038 Run with PWR_DLY=10, SRST_DLY=5, REG_NUM=4; a controller model returns iic_done 20 cycles after estart.
REQ-039 Release rst -> first estart occurs exactly 10 cycles after release, with ewdata=32'h78_3008_82.
REQ-040 Nominal run -> exactly 4 estart pulses; cfg_done=1 one cycle after the 4th iic_done; ewdata fields match the ROM.
REQ-041 Entry 0 completes -> the next estart occurs no earlier than 5 cycles later, with cfg_idx=1.
REQ-042 NACK twice on entry 2 -> entry 2 is issued 3 times; cfg_done is reached, cfg_fail stays 0.
REQ-043 NACK 4 times on entry 1 -> cfg_fail=1; no further estart; cfg_idx=1.
REQ-044 rst pulsed during WAIT_ACK of entry 2, plus a spurious iic_done in PWR_WAIT -> outputs match REQ-031; the spurious pulse is ignored; the sequence restarts at entry 0 after 10 cycles.
